fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'd0: fetch address loaded on start.
REQ-002 Parameter PC_STEP, default 32'd4: increment per fetched word.
REQ-003 Parameter PC_LIMIT, default 32'd65532: last legal fetch address; the address after it wraps to 0.
REQ-004 Ports shall be, in order: clk in 1, rising-edge clock; rst in 1, asynchronous active-high reset.
REQ-005 start in 1: leave IDLE and begin fetching from RESET_PC.
REQ-006 halt in 1: stop fetching, drain the buffer, return to IDLE.
REQ-007 redirect_valid in 1 and redirect_pc in 32: branch target request.
REQ-008 mem_address out 32: address to the combinational instruction memory.
REQ-009 mem_data in 32: memory read data, valid in the same cycle as mem_address.
REQ-010 instr_valid out 1, instr_ready in 1, instr_data out 32, instr_pc out 32: valid/ready output to decode.
REQ-011 busy out 1 (state != IDLE); state out 2 (IDLE=0, RUN=1, DRAIN=2).

Function
REQ-012 pc register drives mem_address combinationally in every state.
REQ-013 2-entry FIFO of {pc, mem_data}; instr_valid = (count != 0); instr_data/instr_pc = head entry.
REQ-014 Pop when instr_valid && instr_ready; instr_data/instr_pc shall not change while instr_valid && !instr_ready.
REQ-015 Push in RUN when count < 2, or count == 2 with a pop in the same cycle; pc advances by PC_STEP only on push.
REQ-016 Latency: word at pc shall appear on instr_data 1 cycle after it is pushed; sustained rate 1 word/cycle with ready held high.
REQ-017 Wrap: push at pc == PC_LIMIT shall load pc = 0.
REQ-018 IDLE: no push, pc holds; start -> RUN with pc = RESET_PC.
REQ-019 RUN: start ignored; halt -> DRAIN; no push in the cycle halt is sampled.
REQ-020 DRAIN: no push; -> IDLE in the cycle after count reaches 0; start and redirect ignored.
REQ-021 Redirect in RUN has priority over push and pop: FIFO flushed (count = 0), no push that cycle, pc = {redirect_pc[31:2], 2'b00}.
REQ-022 Redirect and halt together in RUN: flush plus pc update, then -> DRAIN, then -> IDLE the next cycle.
REQ-023 Redirect in IDLE or DRAIN shall not alter pc or the FIFO.

Reset
REQ-024 rst asserted, at any time including mid-fetch, shall immediately force state = IDLE, pc = RESET_PC, count = 0, FIFO pointers = 0 and instr_valid = 0.
REQ-025 FIFO data storage needs no reset; instr_data/instr_pc are don't-care while instr_valid = 0.

Structure
REQ-026 Package fetch_pkg shall hold the state encoding (IDLE/RUN/DRAIN), the FIFO depth constant 2 and the default PC_STEP/PC_LIMIT.
REQ-027 One sub-module, fetch_fifo2 (2-entry 64-bit sync FIFO with push, pop, flush, count), is instantiated once; the FSM and pc stay in fetch_sequencer.

Verification
REQ-028 Bench memory model: word[0]=3432, [4]=2, [8]=47, [12]=55, [16]=878, [100]=100, [104]=1.
REQ-029 Start with ready=1 -> (pc, data) = (0,3432), (4,2), (8,47), (12,55) on consecutive cycles, instr_valid continuous.
REQ-030 Ready=0 for 5 cycles after start -> count saturates at 2, head holds (0,3432); ready=1 -> (0,3432), (4,2), (8,47) with no gap and no loss.
REQ-031 Redirect_pc=101 while 2 entries are buffered -> next output (100,100), then (104,1); no stale words.
REQ-032 RESET_PC=65528 -> outputs at 65528, 65532, then pc 0 (3432).
REQ-033 Halt with 2 entries buffered -> both delivered, state=DRAIN, then IDLE, busy=0; rst mid-RUN -> instr_valid=0 and state=IDLE immediately, without waiting for clk.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pkg                                                            |
// | Shared types and constants for the instruction fetch sequencer.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fetch_pkg;

  // Encoding is visible on the state output port, so values are fixed.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int          FIFO_DEPTH       = 2;
  localparam logic [31:0] DEFAULT_PC_STEP  = 32'd4;
  localparam logic [31:0] DEFAULT_PC_LIMIT = 32'd65532;

  // One buffered fetch: the address and the word read from it.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_fifo2                                                          |
// | Two-entry synchronous FIFO of {pc, data} with flush and count.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_fifo2
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t rd_entry,
  output logic [1:0]   count
);

  fetch_entry_t store [FIFO_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Flush overrides everything; a push into a full FIFO is allowed only
  // when a pop frees the head slot in the same cycle.
  assign do_pop  = pop && !flush && (count != 2'd0);
  assign do_push = push && !flush && ((count < 2'(FIFO_DEPTH)) || do_pop);

  assign rd_entry = store[rd_ptr];

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Data storage is not reset: contents are ignored while count is zero.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= wr_entry;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_sequencer                                                      |
// | Sequential instruction fetcher: pc register, IDLE/RUN/DRAIN control  |
// | and a two-entry output buffer with valid/ready handshake.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_STEP  = DEFAULT_PC_STEP,
  parameter logic [31:0] PC_LIMIT = DEFAULT_PC_LIMIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_address,
  input  logic [31:0] mem_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        busy,
  output logic [1:0]  state
);

  state_t       state_q;
  state_t       state_d;
  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic         push;
  logic         pop;
  logic         flush;
  logic [1:0]   count;
  fetch_entry_t wr_entry;
  fetch_entry_t rd_entry;

  assign mem_address = pc_q;
  assign wr_entry    = '{pc: pc_q, data: mem_data};
  assign instr_valid = (count != 2'd0);
  assign instr_pc    = rd_entry.pc;
  assign instr_data  = rd_entry.data;
  assign pop         = instr_valid && instr_ready;
  assign busy        = (state_q != IDLE);
  assign state       = state_q;

  fetch_fifo2 u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .wr_entry (wr_entry),
    .rd_entry (rd_entry),
    .count    (count)
  );

  // State and pc registers; reset takes effect without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state, next-pc and FIFO control; redirect outranks halt and push.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = RESET_PC;
        end
      end
      RUN: begin
        if (redirect_valid) begin
          flush = 1'b1;
          pc_d  = {redirect_pc[31:2], 2'b00};
          if (halt) state_d = DRAIN;
        end else if (halt) begin
          state_d = DRAIN;
        end else if ((count < 2'(FIFO_DEPTH)) || pop) begin
          push = 1'b1;
          pc_d = (pc_q == PC_LIMIT) ? 32'd0 : (pc_q + PC_STEP);
        end
      end
      DRAIN: begin
        if (count == 2'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_sequencer                                                   |
// | Scoreboard bench: stimulus pushes the expected fetch stream, a       |
// | negedge monitor pops and compares every delivered word.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fetch_sequencer;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, halt, redirect_valid, instr_ready;
  logic [31:0] redirect_pc;
  logic [31:0] mem_address, mem_data, instr_data, instr_pc;
  logic        instr_valid, busy;
  logic [1:0]  state;

  logic        start_w, halt_w, redirect_valid_w, instr_ready_w;
  logic [31:0] redirect_pc_w;
  logic [31:0] mem_address_w, mem_data_w, instr_data_w, instr_pc_w;
  logic        instr_valid_w, busy_w;
  logic [1:0]  state_w;

  int          vectors = 0;
  int          miscompares = 0;
  int          delivered = 0;
  int          delivered_w = 0;
  bit          model_run = 1'b0;
  exp_t        exp_q[$];
  exp_t        expw_q[$];
  logic [31:0] gen_pc;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_address(mem_address), .mem_data(mem_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc),
    .busy(busy), .state(state)
  );

  fetch_sequencer #(.RESET_PC(32'd65528)) dut_w (
    .clk(clk), .rst(rst), .start(start_w), .halt(halt_w),
    .redirect_valid(redirect_valid_w), .redirect_pc(redirect_pc_w),
    .mem_address(mem_address_w), .mem_data(mem_data_w),
    .instr_valid(instr_valid_w), .instr_ready(instr_ready_w),
    .instr_data(instr_data_w), .instr_pc(instr_pc_w),
    .busy(busy_w), .state(state_w)
  );

  // Instruction memory contents seen by both instances.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'd0:   return 32'd3432;
      32'd4:   return 32'd2;
      32'd8:   return 32'd47;
      32'd12:  return 32'd55;
      32'd16:  return 32'd878;
      32'd100: return 32'd100;
      32'd104: return 32'd1;
      default: return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  always_comb mem_data   = mem_word(mem_address);
  always_comb mem_data_w = mem_word(mem_address_w);

  // Address following p in the fetch stream.
  function automatic logic [31:0] next_pc(input logic [31:0] p);
    return (p == 32'd65532) ? 32'd0 : p + 32'd4;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic topup();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{pc: gen_pc, data: mem_word(gen_pc)});
      gen_pc = next_pc(gen_pc);
    end
  endtask

  task automatic model_restart(input logic [31:0] p);
    exp_q.delete();
    gen_pc = p;
    topup();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (model_run) topup();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    check("idle_reached", {63'd0, busy}, 64'd0);
  endtask

  task automatic launch(input logic rdy);
    instr_ready = rdy;
    model_restart(32'd0);
    model_run = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic stop_run();
    model_run = 1'b0;
    instr_ready = 1'b1;
    halt = 1'b1;
    step();
    halt = 1'b0;
    wait_idle();
  endtask

  // Monitor: every accepted word pops the scoreboard, except a handshake in
  // a redirect cycle, which the flush discards.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && instr_valid && instr_ready && !(redirect_valid && model_run)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {instr_pc, instr_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("delivery", {instr_pc, instr_data}, e);
      end
      delivered++;
    end
    if (!rst && instr_valid_w && instr_ready_w) begin
      if (expw_q.size() == 0) begin
        check("unexpected_word_w", {instr_pc_w, instr_data_w}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = expw_q.pop_front();
        check("delivery_wrap", {instr_pc_w, instr_data_w}, e);
      end
      delivered_w++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [31:0] tgt;
    int r;
    rst = 1'b1; start = 0; halt = 0; redirect_valid = 0; redirect_pc = 0; instr_ready = 0;
    start_w = 0; halt_w = 0; redirect_valid_w = 0; redirect_pc_w = 0; instr_ready_w = 1;
    step(); step();
    check("reset_valid", {63'd0, instr_valid}, 64'd0);
    check("reset_state", {62'd0, state}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_pc", {32'd0, mem_address}, 64'd0);
    check("reset_pc_w", {32'd0, mem_address_w}, 64'd65528);
    rst = 1'b0;
    step();

    // Streaming with ready held high: one word per cycle after one cycle.
    launch(1'b1);
    check("run_state", {62'd0, state}, 64'd1);
    check("run_busy", {63'd0, busy}, 64'd1);
    check("first_latency", {63'd0, instr_valid}, 64'd0);
    d0 = delivered;
    for (int i = 0; i < 4; i++) begin
      step();
      check("stream_valid", {63'd0, instr_valid}, 64'd1);
    end
    step();
    check("stream_rate", 64'(delivered - d0), 64'd4);
    stop_run();

    // Backpressure: buffer fills, head holds, then drains without gaps.
    launch(1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("head_hold", {instr_pc, instr_data}, {32'd0, 32'd3432});
    end
    check("pc_stalled", {32'd0, mem_address}, 64'd8);
    check("fifo_full", {62'd0, dut.u_fifo.count}, 64'd2);
    instr_ready = 1'b1;
    d0 = delivered;
    for (int i = 0; i < 3; i++) begin
      step();
      check("no_gap_valid", {63'd0, instr_valid}, 64'd1);
    end
    check("no_gap_count", 64'(delivered - d0), 64'd3);
    stop_run();

    // Redirect with two words buffered: both discarded, fetch resumes at 100.
    launch(1'b0);
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'd101;
    model_restart(32'd100);
    step();
    redirect_valid = 1'b0;
    check("redirect_flush", {63'd0, instr_valid}, 64'd0);
    check("redirect_pc", {32'd0, mem_address}, 64'd100);
    instr_ready = 1'b1;
    d0 = delivered;
    repeat (3) step();
    check("redirect_count", 64'(delivered - d0), 64'd2);
    stop_run();

    // Halt with two words buffered; a redirect during DRAIN is ignored.
    launch(1'b0);
    repeat (3) step();
    model_run = 1'b0;
    halt = 1'b1;
    d0 = delivered;
    step();
    halt = 1'b0;
    check("drain_state", {62'd0, state}, 64'd2);
    check("drain_busy", {63'd0, busy}, 64'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'd200;
    instr_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    check("drain_redirect_ignored", {32'd0, mem_address}, 64'd8);
    wait_idle();
    check("drain_delivered", 64'(delivered - d0), 64'd2);
    check("drain_to_idle", {62'd0, state}, 64'd0);

    // Asynchronous reset in the middle of a run.
    launch(1'b1);
    repeat (3) step();
    #2;
    rst = 1'b1;
    model_run = 1'b0;
    #1;
    check("async_rst_valid", {63'd0, instr_valid}, 64'd0);
    check("async_rst_state", {62'd0, state}, 64'd0);
    check("async_rst_busy", {63'd0, busy}, 64'd0);
    check("async_rst_pc", {32'd0, mem_address}, 64'd0);
    #2;
    rst = 1'b0;
    step();

    // Address wrap on the instance starting near the limit.
    gen_pc = 32'd65528;
    for (int i = 0; i < 8; i++) begin
      expw_q.push_back('{pc: gen_pc, data: mem_word(gen_pc)});
      gen_pc = next_pc(gen_pc);
    end
    start_w = 1'b1;
    step();
    start_w = 1'b0;
    repeat (5) step();
    check("wrap_count", 64'(delivered_w), 64'd4);
    halt_w = 1'b1;
    step();
    halt_w = 1'b0;
    for (int i = 0; i < 20 && busy_w; i++) step();
    check("wrap_idle", {63'd0, busy_w}, 64'd0);

    // Randomized runs: random backpressure, redirects and ignored starts.
    for (int ep = 0; ep < 6; ep++) begin
      launch(1'b1);
      for (int c = 0; c < 60; c++) begin
        instr_ready = ($urandom_range(0, 3) != 0);
        r = int'($urandom_range(0, 15));
        if (r == 0) begin
          tgt = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 65535)
                                            : 32'd65520 + $urandom_range(0, 15);
          redirect_valid = 1'b1;
          redirect_pc = tgt;
          model_restart({tgt[31:2], 2'b00});
        end else begin
          redirect_valid = 1'b0;
        end
        start = (r == 1);
        step();
      end
      redirect_valid = 1'b0;
      start = 1'b0;
      stop_run();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
